calc_multi_top: RTL and testbench

Parametrised multi-digit BCD add/subtract calculator top; successor to the one-digit calculator. It takes push-switch keys (digits, +, -, =, clear), debounces them, and enters two operands of up to DIGITS decimal digits. It computes the sign-magnitude result with a digit-serial BCD adder/subtractor and drives two scanned 4-digit 7-segment groups.

---
 rtl/calc_multi_top.sv | 232 +++++++++++++++++++++++
 tb/tb_calc_multi_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/calc_multi_top.sv
// calc_multi_top: debounced keypad entry of two BCD operands, digit-serial add/subtract, scanned 7-segment display
module calc_multi_top #(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 100000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [13:0] PSW,
  output logic [7:0]  SEG_1_OUT,
  output logic [3:0]  SEG_SEL_1,
  output logic [7:0]  SEG_2_OUT,
  output logic [3:0]  SEG_SEL_2
);
  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(SCAN_DIV + 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  logic [13:0]   sync_m, sync_s, s0, s1, prev, ev;
  logic [DW-1:0] deb_cnt;
  logic          tick;
  assign tick = deb_cnt == DW'(DEB_CYCLES - 1);

  // ev is a one-cycle pulse raised on the tick that first sees two stable samples
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sync_m  <= '0;
      sync_s  <= '0;
      s0      <= '0;
      s1      <= '0;
      prev    <= '0;
      ev      <= '0;
      deb_cnt <= '0;
    end else begin
      sync_m  <= PSW;
      sync_s  <= sync_m;
      deb_cnt <= tick ? '0 : deb_cnt + 1'b1;
      ev      <= tick ? (s0 & s1 & ~prev) : '0;
      if (tick) begin
        s0   <= sync_s;
        s1   <= s0;
        prev <= s0 & s1;
      end
    end
  end

  logic       clr, eq, pl, mi, dig_v;
  logic [3:0] dig;
  always_comb begin
    clr   = ev[13];
    eq    = ev[12] & ~clr;
    pl    = ev[10] & ~ev[12] & ~clr;
    mi    = ev[11] & ~ev[10] & ~ev[12] & ~clr;
    dig_v = |ev[9:0] & ~|ev[13:10];
    dig   = '0;
    for (int i = 9; i >= 0; i--) if (ev[i]) dig = 4'(i);
  end

  state_t       state, n_state;
  logic [W-1:0] a, b, x, y, n_a, n_b, n_x, n_y;
  logic [W+3:0] r, n_r;
  logic [2:0]   cnt_a, cnt_b, step, n_cnt_a, n_cnt_b, n_step;
  logic         sign, sub, c, n_sign, n_sub, n_c;

  logic [2:0] di;
  logic [3:0] xi, yi, s;
  logic [4:0] sum, dif;
  logic       co, swap;
  always_comb begin
    di   = step == 3'd0 ? 3'd0 : step - 3'd1;
    xi   = x[di*4 +: 4];
    yi   = y[di*4 +: 4];
    sum  = {1'b0, xi} + {1'b0, yi} + {4'b0, c};
    dif  = {1'b0, xi} - {1'b0, yi} - {4'b0, c};
    co   = sub ? dif[4] : sum > 5'd9;
    s    = sub ? (dif[4] ? 4'(dif + 5'd10) : dif[3:0]) : (sum > 5'd9 ? 4'(sum - 5'd10) : sum[3:0]);
    swap = sub && a < b;
  end

  always_comb begin
    n_state = state;
    n_a     = a;
    n_b     = b;
    n_x     = x;
    n_y     = y;
    n_r     = r;
    n_cnt_a = cnt_a;
    n_cnt_b = cnt_b;
    n_step  = step;
    n_sign  = sign;
    n_sub   = sub;
    n_c     = c;
    if (clr) begin
      n_state = ENTER_A;
      n_a     = '0;
      n_b     = '0;
      n_r     = '0;
      n_sign  = 1'b0;
      n_cnt_a = '0;
      n_cnt_b = '0;
    end else begin
      case (state)
        ENTER_A:
          if (dig_v && cnt_a != 3'(DIGITS)) begin
            n_a     = W'({a, dig});
            n_cnt_a = cnt_a + 3'd1;
          end else if (pl || mi) begin
            n_sub   = mi;
            n_b     = '0;
            n_cnt_b = '0;
            n_state = ENTER_B;
          end
        ENTER_B:
          if (dig_v && cnt_b != 3'(DIGITS)) begin
            n_b     = W'({b, dig});
            n_cnt_b = cnt_b + 3'd1;
          end else if (eq) begin
            n_state = CALC;
            n_step  = '0;
          end else if ((pl || mi) && cnt_b == 3'd0) begin
            n_sub = mi;
          end
        CALC:
          if (step == 3'd0) begin
            n_x    = swap ? b : a;
            n_y    = swap ? a : b;
            n_sign = swap;
            n_c    = 1'b0;
            n_step = 3'd1;
          end else begin
            n_r[di*4 +: 4] = s;
            n_c    = co;
            n_step = step + 3'd1;
            if (step == 3'(DIGITS)) begin
              n_r[W +: 4] = {3'b0, ~sub & co};
              n_state     = SHOW;
            end
          end
        default:
          if (dig_v) begin
            n_a     = W'(dig);
            n_cnt_a = 3'd1;
            n_b     = '0;
            n_state = ENTER_A;
          end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= ENTER_A;
      a     <= '0;
      b     <= '0;
      x     <= '0;
      y     <= '0;
      r     <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      step  <= '0;
      sign  <= 1'b0;
      sub   <= 1'b0;
      c     <= 1'b0;
    end else begin
      state <= n_state;
      a     <= n_a;
      b     <= n_b;
      x     <= n_x;
      y     <= n_y;
      r     <= n_r;
      cnt_a <= n_cnt_a;
      cnt_b <= n_cnt_b;
      step  <= n_step;
      sign  <= n_sign;
      sub   <= n_sub;
      c     <= n_c;
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [15:0]   a16, b16, r16;
  logic [3:0]    d1, carry;
  logic [7:0]    g1, g2;
  always_comb begin
    a16   = 16'(a);
    b16   = 16'(b);
    r16   = 16'(r);
    carry = r[W +: 4];
    d1    = state == ENTER_A ? a16[idx*4 +: 4] : state == SHOW ? r16[idx*4 +: 4] : b16[idx*4 +: 4];
    g1    = int'(idx) < DIGITS ? seg7(d1) : 8'h00;
    g2    = idx == 2'd0 ? (state == SHOW && carry != 4'd0 ? seg7(carry) : 8'h00) :
            idx == 2'd1 ? (state == SHOW && sign ? 8'h40 : 8'h00) :
            idx == 2'd3 ? (state == ENTER_A ? 8'h77 : state == ENTER_B ? 8'h7C : 8'h00) : 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      scan_cnt  <= '0;
      idx       <= '0;
      SEG_1_OUT <= '0;
      SEG_2_OUT <= '0;
      SEG_SEL_1 <= '0;
      SEG_SEL_2 <= '0;
    end else begin
      scan_cnt  <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
      idx       <= scan_cnt == SW'(SCAN_DIV - 1) ? idx + 2'd1 : idx;
      SEG_1_OUT <= g1;
      SEG_2_OUT <= g2;
      SEG_SEL_1 <= 4'b0001 << idx;
      SEG_SEL_2 <= 4'b0001 << idx;
    end
  end
endmodule

// File: tb/tb_calc_multi_top.sv
// tb_calc_multi_top: directed key-sequence vectors checked against the scanned display, plus timing corner cases
module tb_calc_multi_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] psw = '0;
  logic [7:0]  seg1, seg2;
  logic [3:0]  sel1, sel2;
  int          tests = 0;
  int          fails = 0;

  calc_multi_top #(.DIGITS(4), .DEB_CYCLES(4), .SCAN_DIV(2)) dut (
    .CLK(clk), .RST_X(rst_n), .PSW(psw),
    .SEG_1_OUT(seg1), .SEG_SEL_1(sel1), .SEG_2_OUT(seg2), .SEG_SEL_2(sel2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       keys;
    logic [31:0] g1;
    logic [31:0] g2;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input int k, input int hold = 12);
    @(negedge clk);
    psw[k] = 1'b1;
    repeat (hold) @(negedge clk);
    psw[k] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  function automatic int key_idx(input byte ch);
    return ch == "+" ? 10 : ch == "-" ? 11 : ch == "=" ? 12 : ch == "c" ? 13 : int'(ch) - 48;
  endfunction

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) press(key_idx(s[i]));
    repeat (12) @(negedge clk);
  endtask

  // collect each group as {idx3,idx2,idx1,idx0} over more than one full scan
  task automatic scan(output logic [31:0] g1, output logic [31:0] g2);
    g1 = '0;
    g2 = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sel1 == 4'(1 << i)) g1[i*8 +: 8] = seg1;
        if (sel2 == 4'(1 << i)) g2[i*8 +: 8] = seg2;
      end
    end
  endtask

  initial begin
    logic [31:0] g1, g2;
    int lat, wait_n;
    vecs[0]  = '{"12+34=",     32'h3F3F667D, 32'h00000000};
    vecs[1]  = '{"9999+9999=", 32'h6F6F6F7F, 32'h00000006};
    vecs[2]  = '{"3-25=",      32'h3F3F5B5B, 32'h00004000};
    vecs[3]  = '{"12",         32'h3F3F065B, 32'h77000000};
    vecs[4]  = '{"12345",      32'h065B4F66, 32'h77000000};
    vecs[5]  = '{"7+",         32'h3F3F3F3F, 32'h7C000000};
    vecs[6]  = '{"5+-3=",      32'h3F3F3F5B, 32'h00000000};
    vecs[7]  = '{"5+3-=",      32'h3F3F3F7F, 32'h00000000};
    vecs[8]  = '{"50-50=",     32'h3F3F3F3F, 32'h00000000};
    vecs[9]  = '{"12+34=7",    32'h3F3F3F07, 32'h77000000};
    vecs[10] = '{"4=",         32'h3F3F3F66, 32'h77000000};
    vecs[11] = '{"1+2=+",      32'h3F3F3F4F, 32'h00000000};
    vecs[12] = '{"1234-1235=", 32'h3F3F3F06, 32'h00004000};
    vecs[13] = '{"5000+5000=", 32'h3F3F3F3F, 32'h00000006};
    vecs[14] = '{"12c",        32'h3F3F3F3F, 32'h77000000};

    #1;
    check("reset_sel", {24'h0, sel1, sel2}, 32'h0);
    check("reset_seg", {16'h0, seg1, seg2}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_sel", {24'h0, sel1, sel2}, 32'h11);

    for (int i = 0; i < 15; i++) begin
      enter({"c", vecs[i].keys});
      scan(g1, g2);
      check({"g1 ", vecs[i].keys}, g1, vecs[i].g1);
      check({"g2 ", vecs[i].keys}, g2, vecs[i].g2);
    end

    // equals event to SHOW latency
    enter("c12+34");
    @(negedge clk);
    psw[12] = 1'b1;
    lat = -1;
    wait_n = 0;
    while (!dut.ev[12] && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    if (dut.ev[12]) begin
      lat = 0;
      while (dut.state != 2'd3 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
    end
    check("calc_latency", 32'(lat), 32'd6);
    psw[12] = 1'b0;
    repeat (12) @(negedge clk);

    // clear landing one tick after equals arrives mid-CALC
    enter("c12+34");
    @(negedge clk);
    psw[12] = 1'b1;
    repeat (4) @(negedge clk);
    psw[13] = 1'b1;
    wait_n = 0;
    while (!dut.ev[13] && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("clr_seen_in_calc", {30'h0, dut.state}, 32'd2);
    @(negedge clk);
    check("clr_calc_state", {30'h0, dut.state}, 32'd0);
    check("clr_calc_r", 32'(dut.r), 32'h0);
    psw[12] = 1'b0;
    psw[13] = 1'b0;
    repeat (12) @(negedge clk);

    press(13);
    press(5, 3);
    scan(g1, g2);
    check("short_press_a", 32'(dut.a), 32'h0);
    check("short_press_g1", g1, 32'h3F3F3F3F);
    press(5, 12);
    scan(g1, g2);
    check("long_press_a", 32'(dut.a), 32'h0005);
    check("long_press_g1", g1, 32'h3F3F3F6D);

    @(negedge clk);
    psw[1] = 1'b1;
    psw[13] = 1'b1;
    repeat (12) @(negedge clk);
    psw = '0;
    repeat (12) @(negedge clk);
    check("clr_wins_a", 32'(dut.a), 32'h0);
    scan(g1, g2);
    check("clr_wins_g1", g1, 32'h3F3F3F3F);

    enter("c12");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_out", {seg1, seg2, sel1, sel2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a", 32'(dut.a), 32'h0);
    scan(g1, g2);
    check("rst_g1", g1, 32'h3F3F3F3F);
    check("rst_g2", g2, 32'h77000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
